// File: rtl/mole_hit_arbiter_pkg.sv
// mole_hit_arbiter_pkg: shared FSM state, counter width and default sizes for the whack-a-mole hit arbiter.
package mole_hit_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  localparam int DROP_CNT_W = 8;
  localparam int DEF_NUM_BTN = 9;
  localparam int DEF_FIFO_DEPTH = 4;
  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b >= n) ? a + b - n : a + b;
  endfunction
endpackage

// File: rtl/mole_hit_arbiter_rr_arbiter.sv
// rr_arbiter: single-grant round-robin picker, ascending search from ptr with wrap.
module rr_arbiter
  import mole_hit_arbiter_pkg::*;
#(
  parameter int N = DEF_NUM_BTN,
  parameter int IW = $clog2(DEF_NUM_BTN)
) (
  input  logic [N-1:0]  i_req,
  input  logic          i_en,
  input  logic [IW-1:0] i_ptr,
  output logic          o_gnt_valid,
  output logic [IW-1:0] o_gnt_idx
);
  logic [IW-1:0] w_i;
  // Scan farthest-first so the request closest to ptr is the last (winning) assignment.
  always_comb begin
    o_gnt_valid = 1'b0;
    o_gnt_idx = '0;
    w_i = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_i = IW'(wrap_add(int'(i_ptr), k, N));
      if (i_en && i_req[w_i]) begin
        o_gnt_valid = 1'b1;
        o_gnt_idx = w_i;
      end
    end
  end
endmodule

// File: rtl/mole_hit_arbiter.sv
// mole_hit_arbiter: latches button presses, round-robin grants them into a hit queue.
// Define HIT_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise the queue is one holding register.
module mole_hit_arbiter
  import mole_hit_arbiter_pkg::*;
#(
  parameter int NUM_BTN = DEF_NUM_BTN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       game_en,
  input  logic [NUM_BTN-1:0]         press,
  input  logic                       hit_ready,
  output logic                       hit_valid,
  output logic [$clog2(NUM_BTN)-1:0] hit_idx,
  output logic [NUM_BTN-1:0]         pending,
  output logic [DROP_CNT_W-1:0]      drop_cnt,
  output logic                       busy
);
  localparam int IW = $clog2(NUM_BTN);
`ifdef HIT_FIFO_EN
  localparam int QD = FIFO_DEPTH;
`else
  localparam int QD = 1;
`endif
  localparam int CW = $clog2(QD + 1);
  localparam int AW = (QD > 1) ? $clog2(QD) : 1;

  if (NUM_BTN < 2 || NUM_BTN > 16 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("mole_hit_arbiter: unsupported NUM_BTN or FIFO_DEPTH");
  end

  state_e                r_state;
  logic [IW-1:0]         r_ptr;
  logic [NUM_BTN-1:0]    r_pending;
  logic [DROP_CNT_W-1:0] r_drop;
  logic [IW-1:0]         r_q [QD];
  logic [CW-1:0]         r_cnt;
  logic                  w_empty, w_full, w_pop, w_arb_en, w_gnt_valid;
  logic [IW-1:0]         w_gnt_idx;
  logic [NUM_BTN-1:0]    w_gmask, w_drops;
  logic [AW-1:0]         w_wr;
  logic [DROP_CNT_W:0]   w_drop_sum;

  assign w_empty = r_cnt == '0;
  assign w_full = r_cnt == CW'(QD);
  assign w_pop = !w_empty && hit_ready;
  // A pop frees a slot in the same cycle, so a full queue can still accept a grant.
  assign w_arb_en = r_state == RUN && (!w_full || w_pop);
  assign w_gmask = w_gnt_valid ? NUM_BTN'(1) << w_gnt_idx : '0;
  assign w_drops = (r_state == RUN) ? press & r_pending & ~w_gmask : '0;
  assign w_wr = AW'(r_cnt - CW'(w_pop));

  always_comb begin
    w_drop_sum = {1'b0, r_drop};
    for (int i = 0; i < NUM_BTN; i++) w_drop_sum = w_drop_sum + (DROP_CNT_W + 1)'(w_drops[i]);
  end

  rr_arbiter #(.N(NUM_BTN), .IW(IW)) u_arb (
    .i_req(r_pending),
    .i_en(w_arb_en),
    .i_ptr(r_ptr),
    .o_gnt_valid(w_gnt_valid),
    .o_gnt_idx(w_gnt_idx)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_pending <= '0;
      r_drop <= '0;
      r_cnt <= '0;
      for (int i = 0; i < QD; i++) r_q[i] <= '0;
    end else begin
      r_state <= game_en ? RUN : (r_state == RUN || (r_state == DRAIN && !w_empty)) ? DRAIN : IDLE;
      r_pending <= (r_state == RUN) ? (r_pending & ~w_gmask) | press : '0;
      r_drop <= w_drop_sum[DROP_CNT_W] ? '1 : w_drop_sum[DROP_CNT_W-1:0];
      if (w_gnt_valid) r_ptr <= IW'(wrap_add(int'(w_gnt_idx), 1, NUM_BTN));
      r_cnt <= r_cnt + CW'(w_gnt_valid) - CW'(w_pop);
      if (w_pop) for (int i = 0; i < QD - 1; i++) r_q[i] <= r_q[i+1];
      if (w_gnt_valid) r_q[w_wr] <= w_gnt_idx;
    end
  end

  assign hit_valid = !w_empty;
  assign hit_idx = r_q[0];
  assign pending = r_pending;
  assign drop_cnt = r_drop;
  assign busy = r_state != IDLE;
endmodule

// File: tb/tb_mole_hit_arbiter.sv
// tb_mole_hit_arbiter: table-driven and directed checks for mole_hit_arbiter (default sizes).
module tb_mole_hit_arbiter;
`ifdef HIT_FIFO_EN
  localparam int QD = 4;
`else
  localparam int QD = 1;
`endif
  logic       clk, rst_n, game_en, hit_ready, hit_valid, busy;
  logic [8:0] press, pending;
  logic [3:0] hit_idx;
  logic [7:0] drop_cnt;
  int n_chk, n_err, n;

  mole_hit_arbiter dut (
    .clk(clk), .rst_n(rst_n), .game_en(game_en), .press(press), .hit_ready(hit_ready),
    .hit_valid(hit_valid), .hit_idx(hit_idx), .pending(pending), .drop_cnt(drop_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct packed {
    logic       en;
    logic [8:0] press;
    logic       rdy;
    logic       vld;
    logic [3:0] idx;
    logic [8:0] pend;
    logic       busy;
  } vec_t;
  vec_t tv [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] bits(input int lo, input int hi);
    logic [8:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  initial begin
    n_chk = 0; n_err = 0;
    game_en = 0; press = '0; hit_ready = 0;
    rst_n = 0;
    #1 rst_n = 1;
    #1;
    chk("rst_valid", 32'(hit_valid), 0);
    chk("rst_idx", 32'(hit_idx), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 0;

    // en, press, rdy | valid, idx, pending, busy
    tv[0]  = '{1'b1, 9'h000, 1'b1, 1'b0, 4'd0, 9'h000, 1'b0};
    tv[1]  = '{1'b1, 9'h020, 1'b1, 1'b0, 4'd0, 9'h000, 1'b1};
    tv[2]  = '{1'b1, 9'h000, 1'b1, 1'b0, 4'd0, 9'h020, 1'b1};
    tv[3]  = '{1'b1, 9'h000, 1'b1, 1'b1, 4'd5, 9'h000, 1'b1};
    tv[4]  = '{1'b1, 9'h100, 1'b1, 1'b0, 4'd0, 9'h000, 1'b1};
    tv[5]  = '{1'b1, 9'h000, 1'b1, 1'b0, 4'd0, 9'h100, 1'b1};
    tv[6]  = '{1'b1, 9'h085, 1'b1, 1'b1, 4'd8, 9'h000, 1'b1};
    tv[7]  = '{1'b1, 9'h000, 1'b1, 1'b0, 4'd0, 9'h085, 1'b1};
    tv[8]  = '{1'b1, 9'h000, 1'b1, 1'b1, 4'd0, 9'h084, 1'b1};
    tv[9]  = '{1'b1, 9'h000, 1'b1, 1'b1, 4'd2, 9'h080, 1'b1};
    tv[10] = '{1'b1, 9'h102, 1'b1, 1'b1, 4'd7, 9'h000, 1'b1};
    tv[11] = '{1'b1, 9'h000, 1'b1, 1'b0, 4'd0, 9'h102, 1'b1};
    tv[12] = '{1'b1, 9'h000, 1'b1, 1'b1, 4'd8, 9'h002, 1'b1};
    tv[13] = '{1'b1, 9'h000, 1'b1, 1'b1, 4'd1, 9'h000, 1'b1};
    tv[14] = '{1'b1, 9'h000, 1'b1, 1'b0, 4'd0, 9'h000, 1'b1};
    for (int i = 0; i < 15; i++) begin
      game_en = tv[i].en; press = tv[i].press; hit_ready = tv[i].rdy;
      @(negedge clk);
      chk($sformatf("tv%0d_valid", i), 32'(hit_valid), 32'(tv[i].vld));
      chk($sformatf("tv%0d_pending", i), 32'(pending), 32'(tv[i].pend));
      chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].busy));
      if (tv[i].vld) chk($sformatf("tv%0d_idx", i), 32'(hit_idx), 32'(tv[i].idx));
      step;
    end
    press = '0;
    chk("tv_drop", 32'(drop_cnt), 0);

    // Queue fill with presses 1..5, consumer stalled
    hit_ready = 0;
    for (int i = 1; i <= 5; i++) begin
      press = 9'(1) << i;
      step;
    end
    press = '0;
    repeat (3) step;
    @(negedge clk);
    chk("fill_valid", 32'(hit_valid), 1);
    chk("fill_idx", 32'(hit_idx), 1);
    chk("fill_pending", 32'(pending), 32'(bits(QD + 1, 5)));
    chk("fill_drop", 32'(drop_cnt), 0);
    hit_ready = 1;
    step;
    hit_ready = 0;
    @(negedge clk);
    chk("pop1_idx", 32'({hit_valid, hit_idx}), 32'({1'b1, 4'd2}));
    chk("pop1_pending", 32'(pending), 32'(bits(QD + 2, 5)));
    for (int v = 2; v <= 5; v++) begin
      @(negedge clk);
      chk($sformatf("fill_order%0d", v), 32'({hit_valid, hit_idx}), 32'({1'b1, 4'(v)}));
      hit_ready = 1;
      step;
    end
    hit_ready = 0;
    @(negedge clk);
    chk("fill_empty", 32'(hit_valid), 0);
    chk("fill_pending0", 32'(pending), 0);

    // Duplicate presses while stalled behind a full queue
    for (int q = 0; q < QD; q++) begin
      press = 9'(1) << (4 + q);
      step;
    end
    press = '0;
    repeat (3) step;
    press = 9'h008;
    repeat (3) step;
    press = '0;
    @(negedge clk);
    chk("dup_drop", 32'(drop_cnt), 2);
    chk("dup_pending", 32'(pending), 32'h008);
    press = 9'h008; hit_ready = 1;
    step;
    press = '0; hit_ready = 0;
    @(negedge clk);
    chk("regrant_drop", 32'(drop_cnt), 2);
    chk("regrant_pending", 32'(pending), 32'h008);
    chk("regrant_head", 32'({hit_valid, hit_idx}), 32'({1'b1, (QD > 1) ? 4'd5 : 4'd3}));

    // Round end: drain in order, presses ignored
    game_en = 0;
    step;
    @(negedge clk);
    chk("drain_busy", 32'(busy), 1);
    press = 9'h002;
    step;
    press = '0;
    @(negedge clk);
    chk("drain_pending", 32'(pending), 0);
    chk("drain_drop", 32'(drop_cnt), 2);
    for (int q = 0; q < QD; q++) begin
      @(negedge clk);
      chk($sformatf("drain_order%0d", q), 32'({hit_valid, hit_idx}), 32'({1'b1, (q < QD - 1) ? 4'(5 + q) : 4'd3}));
      hit_ready = 1;
      step;
    end
    hit_ready = 0;
    n = 0;
    while (busy && n < 4) begin
      step;
      n++;
    end
    chk("idle_busy", 32'(busy), 0);
    chk("idle_valid", 32'(hit_valid), 0);
    press = 9'h040;
    step;
    press = '0;
    @(negedge clk);
    chk("idle_pending", 32'(pending), 0);
    chk("idle_drop", 32'(drop_cnt), 2);

    // Drop counter saturation
    game_en = 1; press = 9'h008;
    repeat (300) step;
    press = '0;
    @(negedge clk);
    chk("sat_drop", 32'(drop_cnt), 255);

    // Asynchronous reset in the middle of DRAIN
    game_en = 0;
    step; step;
    @(negedge clk);
    chk("pre_rst_valid", 32'(hit_valid), 1);
    chk("pre_rst_busy", 32'(busy), 1);
    rst_n = 1;
    #1;
    chk("arst_valid", 32'(hit_valid), 0);
    chk("arst_idx", 32'(hit_idx), 0);
    chk("arst_pending", 32'(pending), 0);
    chk("arst_drop", 32'(drop_cnt), 0);
    chk("arst_busy", 32'(busy), 0);
    step;
    rst_n = 0;
    step;
    @(negedge clk);
    chk("post_rst_valid", 32'(hit_valid), 0);
    chk("post_rst_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mole_hit_arbiter.md
MOLE_HIT_ARBITER -- requirements
Module: mole_hit_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_BTN, default 9, meaning the number of debounced hole buttons (range 2..16).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the hit queue depth (power of two, ≥2); it is used only with HIT_FIFO_EN.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-high (asserted = 1).
REQ-005 The block SHALL have port game_en, input, 1 bit: round active level from the game FSM.
REQ-006 The block SHALL have port press, input, NUM_BTN bits: one-cycle press pulses, one per button.
REQ-007 The block SHALL have port hit_ready, input, 1 bit: the consumer accepts a hit.
REQ-008 The block SHALL have port hit_valid, output, 1 bit: a hit is presented.
REQ-009 The block SHALL have port hit_idx, output, $clog2(NUM_BTN) bits: the index of the presented hit.
REQ-010 The block SHALL have port pending, output, NUM_BTN bits: presses latched but not yet granted.
REQ-011 The block SHALL have port drop_cnt, output, 8 bits: saturating count of discarded presses.
REQ-012 The block SHALL have port busy, output, 1 bit: high in the RUN and DRAIN states.

Function
REQ-013 The block SHALL implement the FSM states IDLE, RUN and DRAIN.
  - IDLE→RUN when game_en=1.
  - RUN→DRAIN when game_en=0.
  - DRAIN→IDLE when the queue is empty.
  - DRAIN→RUN when game_en=1.
REQ-014 In RUN only, a press[i] pulse SHALL set pending[i] at the next edge; in IDLE and DRAIN, presses SHALL be ignored and not counted.
REQ-015 A press[i] arriving while pending[i]=1 and no grant to i occurs that cycle SHALL be discarded and SHALL increment drop_cnt, which saturates at 255.
REQ-016 Each cycle in RUN, the round-robin arbiter SHALL grant at most one pending bit.
  - Search starts at pointer ptr, ascending, wrapping at NUM_BTN-1 to 0.
  - On grant of index g, ptr SHALL become (g+1) mod NUM_BTN.
REQ-017 A grant SHALL occur only when the queue is not full, or when a pop (hit_valid & hit_ready) occurs in the same cycle.
REQ-018 A grant SHALL clear pending[g] and push g into the queue.
  - A same-cycle press[g] SHALL set pending[g] again: set wins over clear, and drop_cnt is not incremented.
REQ-019 In DRAIN, pending SHALL be cleared at the first edge, and no grants SHALL occur.
REQ-020 The queue output SHALL be FIFO-ordered.
  - hit_valid = queue not empty; hit_idx = head entry.
  - A pop occurs on hit_valid & hit_ready.
  - hit_idx SHALL be stable while hit_valid=1 and hit_ready=0.
REQ-021 Latency: a press in cycle k (RUN, queue empty, no competing pending) SHALL produce hit_valid=1 with the matching hit_idx in cycle k+2.
REQ-022 A full queue SHALL stall grants without losing pending bits; only duplicate presses are dropped.

Reset
REQ-023 While rst_n=1, the block SHALL hold the following values, applied asynchronously:
  - state=IDLE, ptr=0, pending=0.
  - queue empty, hit_valid=0, hit_idx=0.
  - drop_cnt=0, busy=0.
REQ-024 Reset mid-round SHALL discard all queued hits and pending bits, with no partial pop.
REQ-025 The block SHALL leave reset only on a clean clock edge; the first grant occurs no earlier than the second edge after rst_n falls.

Configuration
REQ-026 With macro HIT_FIFO_EN defined, the queue SHALL be a FIFO_DEPTH-entry FIFO.
REQ-027 Without HIT_FIFO_EN, the queue SHALL be a single holding register (depth 1); all other behaviour is unchanged, including the same-cycle pop+grant of REQ-017.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE/RUN/DRAIN), the DROP_CNT_W=8 constant and the default NUM_BTN/FIFO_DEPTH constants.
REQ-029 The arbiter SHALL be a sub-module rr_arbiter, with request vector, enable and ptr in, and grant valid/index out; the FSM, pending register and queue SHALL reside in mole_hit_arbiter.

Verification
REQ-030 With game_en=1 and press[5] pulsed in cycle 10, hit_ready=1: hit_valid=1 and hit_idx=5 in cycle 12; one cycle only.
REQ-031 With ptr=0, press[2], press[7] and press[0] pulsed in the same cycle, hit_ready=1: hits SHALL be 0, 2, 7 on consecutive cycles, and ptr=8 afterwards.
REQ-032 With HIT_FIFO_EN, hit_ready=0, and presses 1,2,3,4,5 one per cycle: 4 hits queued, pending=0b000100000; after one pop, 5 enters the queue; drop_cnt=0.
REQ-033 With press[3] pulsed twice while pending[3]=1 and the queue full: drop_cnt=2; press[3] again coinciding with its grant: drop_cnt stays 2 and pending[3]=1.
REQ-034 Drop game_en with 2 hits queued and pending≠0: pending=0 next cycle, the 2 hits drain in order, IDLE follows the last pop, busy=0; a press during DRAIN is ignored.
REQ-035 Assert rst_n mid-DRAIN with hit_valid=1: all outputs reach their reset values immediately, without waiting for a clock edge.
